// File: rtl/p2s_serializer_pkg.sv
// Shared types and defaults for the stereo parallel-to-serial output block.
package p2s_serializer_pkg;

    localparam int unsigned OUT_WIDTH_DEFAULT = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } FSMState;

    // Bit counter width; a one-bit word still needs a one-bit counter.
    function automatic int unsigned cntWidth(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/p2s_serializer_if.sv
// Handshake, data and status bundle between the main controller and p2s_serializer.
interface p2s_serializer_if #(
    parameter int unsigned OUT_WIDTH = 40
) ();
    logic                 frame;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] in_data_l;
    logic [OUT_WIDTH-1:0] in_data_r;
    logic                 ser_out_l;
    logic                 ser_out_r;
    logic                 out_ready;
    logic                 tx_done;
    logic                 underrun;
    logic                 frame_err;

    modport master (
        output frame, in_valid, in_data_l, in_data_r,
        input  in_ready, ser_out_l, ser_out_r, out_ready, tx_done, underrun, frame_err
    );

    modport slave (
        input  frame, in_valid, in_data_l, in_data_r,
        output in_ready, ser_out_l, ser_out_r, out_ready, tx_done, underrun, frame_err
    );
endinterface

// File: rtl/p2s_shift_chan.sv
// Single-channel MSB-first shifter: a word can be parked (load) or launched (start),
// and the serial bit is a register so it reads 0 whenever nothing is being sent.
module p2s_shift_chan #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             sclk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             start,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             serOut
);
    logic [WIDTH-1:0] shiftReg;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            shiftReg <= '0;
            serOut   <= 1'b0;
        end else if (clear) begin
            shiftReg <= '0;
            serOut   <= 1'b0;
        end else if (load) begin
            shiftReg <= data;
            serOut   <= 1'b0;
        end else if (start) begin
            shiftReg <= {data[WIDTH-2:0], 1'b0};
            serOut   <= data[WIDTH-1];
        end else if (shift) begin
            shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
            serOut   <= shiftReg[WIDTH-1];
        end
    end
endmodule

// File: rtl/p2s_serializer.sv
// Stereo parallel-to-serial output stage, frame-aligned, MSB first.
// Define P2S_DOUBLE_BUF_EN to add a holding register so the next pair is taken during SHIFT.
module p2s_serializer
    import p2s_serializer_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEFAULT
) (
    input  logic                  sclk,
    input  logic                  reset_n,
    p2s_serializer_if.slave       bus
);
    localparam int unsigned          CNT_WIDTH = cntWidth(OUT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(OUT_WIDTH - 1);

    FSMState              state, stateNext;
    logic [CNT_WIDTH-1:0] bitCnt, bitCntNext;
    logic                 outReadyNext, txDoneNext, underrunNext, frameErrNext, inReadyNext;
    logic                 shClear, shLoad, shStart, shShift;
    logic                 accept;
    logic [OUT_WIDTH-1:0] srcL, srcR;

    assign accept = bus.in_valid && bus.in_ready;

`ifdef P2S_DOUBLE_BUF_EN
    logic [OUT_WIDTH-1:0] holdL, holdR;
    logic                 holdValid, holdValidNext, holdLoad, holdClear, useHold;

    assign srcL = useHold ? holdL : bus.in_data_l;
    assign srcR = useHold ? holdR : bus.in_data_r;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            holdL     <= '0;
            holdR     <= '0;
            holdValid <= 1'b0;
        end else if (holdLoad) begin
            holdL     <= bus.in_data_l;
            holdR     <= bus.in_data_r;
            holdValid <= 1'b1;
        end else if (holdClear) begin
            holdValid <= 1'b0;
        end
    end
`else
    assign srcL = bus.in_data_l;
    assign srcR = bus.in_data_r;
`endif

    // Next state, shifter controls and next values of the registered outputs.
    always_comb begin
        stateNext    = state;
        bitCntNext   = bitCnt;
        outReadyNext = 1'b0;
        txDoneNext   = 1'b0;
        underrunNext = 1'b0;
        frameErrNext = 1'b0;
        shClear      = 1'b0;
        shLoad       = 1'b0;
        shStart      = 1'b0;
        shShift      = 1'b0;
`ifdef P2S_DOUBLE_BUF_EN
        holdLoad     = 1'b0;
        holdClear    = 1'b0;
        useHold      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept && bus.frame) begin
                    shStart      = 1'b1;
                    bitCntNext   = CNT_LAST;
                    outReadyNext = 1'b1;
                    stateNext    = SHIFT;
                end else if (accept) begin
                    shLoad    = 1'b1;
                    stateNext = ARMED;
                end else if (bus.frame) begin
                    underrunNext = 1'b1;
                end
            end
            ARMED: begin
                // Parked word already sits in the shifter; a shift launches its MSB.
                if (bus.frame) begin
                    shShift      = 1'b1;
                    bitCntNext   = CNT_LAST;
                    outReadyNext = 1'b1;
                    stateNext    = SHIFT;
                end
`ifdef P2S_DOUBLE_BUF_EN
                holdLoad = accept;
`endif
            end
            SHIFT: begin
                if (bitCnt != '0) begin
                    shShift      = 1'b1;
                    bitCntNext   = bitCnt - CNT_WIDTH'(1);
                    outReadyNext = 1'b1;
                    frameErrNext = bus.frame;
`ifdef P2S_DOUBLE_BUF_EN
                    holdLoad     = accept;
`endif
                end else begin
                    txDoneNext = 1'b1;
                    bitCntNext = '0;
`ifdef P2S_DOUBLE_BUF_EN
                    // A held (or just-offered) word follows with no gap if framed now.
                    useHold   = holdValid;
                    holdClear = holdValid;
                    if (holdValid || accept) begin
                        if (bus.frame) begin
                            shStart      = 1'b1;
                            bitCntNext   = CNT_LAST;
                            outReadyNext = 1'b1;
                            stateNext    = SHIFT;
                        end else begin
                            shLoad    = 1'b1;
                            stateNext = ARMED;
                        end
                    end else begin
                        shClear      = 1'b1;
                        frameErrNext = bus.frame;
                        stateNext    = IDLE;
                    end
`else
                    shClear      = 1'b1;
                    frameErrNext = bus.frame;
                    stateNext    = IDLE;
`endif
                end
            end
            default: begin
                shClear   = 1'b1;
                stateNext = IDLE;
            end
        endcase
`ifdef P2S_DOUBLE_BUF_EN
        holdValidNext = holdLoad || (holdValid && !holdClear);
        inReadyNext   = !holdValidNext;
`else
        inReadyNext   = (stateNext == IDLE);
`endif
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bitCnt        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_ready <= 1'b0;
            bus.tx_done   <= 1'b0;
            bus.underrun  <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            state         <= stateNext;
            bitCnt        <= bitCntNext;
            bus.in_ready  <= inReadyNext;
            bus.out_ready <= outReadyNext;
            bus.tx_done   <= txDoneNext;
            bus.underrun  <= underrunNext;
            bus.frame_err <= frameErrNext;
        end
    end

    p2s_shift_chan #(.WIDTH(OUT_WIDTH)) chanL (
        .sclk    (sclk),
        .reset_n (reset_n),
        .clear   (shClear),
        .load    (shLoad),
        .start   (shStart),
        .shift   (shShift),
        .data    (srcL),
        .serOut  (bus.ser_out_l)
    );

    p2s_shift_chan #(.WIDTH(OUT_WIDTH)) chanR (
        .sclk    (sclk),
        .reset_n (reset_n),
        .clear   (shClear),
        .load    (shLoad),
        .start   (shStart),
        .shift   (shShift),
        .data    (srcR),
        .serOut  (bus.ser_out_r)
    );
endmodule

// File: tb/tb_p2s_serializer.sv
// Directed self-checking bench for p2s_serializer; honours P2S_DOUBLE_BUF_EN when defined.
module tb_p2s_serializer;
    localparam int unsigned W = 40;

`ifdef P2S_DOUBLE_BUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic sclk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    p2s_serializer_if #(.OUT_WIDTH(W)) bus ();

    p2s_serializer #(.OUT_WIDTH(W)) dut (
        .sclk    (sclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic loadPair(input logic [W-1:0] l, input logic [W-1:0] r);
        bus.in_data_l = l;
        bus.in_data_r = r;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic pulseFrame();
        bus.frame = 1'b1;
        tick();
        bus.frame = 1'b0;
    endtask

    // Collects one word starting from the bit already on the outputs; optionally
    // raises frame / offers a pair on the given cycle index.
    task automatic shiftOut(input int frameAt, input int validAt,
                            input logic [W-1:0] vl, input logic [W-1:0] vr,
                            output logic [W-1:0] gotL, output logic [W-1:0] gotR,
                            output int orCnt, output int irCnt,
                            output int errCnt, output int doneCnt);
        gotL = '0; gotR = '0;
        orCnt = 0; irCnt = 0; errCnt = 0; doneCnt = 0;
        for (int cyc = 0; cyc < int'(W); cyc++) begin
            gotL     = {gotL[W-2:0], bus.ser_out_l};
            gotR     = {gotR[W-2:0], bus.ser_out_r};
            orCnt   += int'(bus.out_ready);
            irCnt   += int'(bus.in_ready);
            errCnt  += int'(bus.frame_err);
            doneCnt += int'(bus.tx_done);
            bus.frame     = (cyc == frameAt);
            bus.in_valid  = (cyc == validAt);
            bus.in_data_l = vl;
            bus.in_data_r = vr;
            tick();
        end
        bus.frame    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [5:0] outVec();
        return {bus.ser_out_l, bus.ser_out_r, bus.out_ready, bus.tx_done, bus.underrun, bus.frame_err};
    endfunction

    logic [W-1:0] gotL, gotR;
    int           orCnt, irCnt, errCnt, doneCnt;

    initial begin
        reset_n       = 1'b0;
        bus.frame     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data_l = '0;
        bus.in_data_r = '0;
        #12;
        checkEq("reset_outs", 64'(outVec()), 64'd0);
        checkEq("reset_in_ready", 64'(bus.in_ready), 64'd1);
        reset_n = 1'b1;

        // Frame with nothing loaded, first edge after reset.
        bus.frame = 1'b1;
        tick();
        bus.frame = 1'b0;
        checkEq("underrun_pulse", 64'(outVec()), 64'b00_0010);
        checkEq("underrun_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        checkEq("underrun_clear", 64'(outVec()), 64'd0);

        // Basic word, held in ARMED for a couple of cycles first.
        loadPair(40'hF0_0000_000F, 40'h00_1234_5678);
        checkEq("armed_outs", 64'(outVec()), 64'd0);
        checkEq("armed_in_ready", 64'(bus.in_ready), 64'(DBUF));
        tick();
        tick();
        checkEq("armed_wait_outs", 64'(outVec()), 64'd0);
        pulseFrame();
        shiftOut(-1, -1, '0, '0, gotL, gotR, orCnt, irCnt, errCnt, doneCnt);
        checkEq("basic_word_l", 64'(gotL), 64'hF0_0000_000F);
        checkEq("basic_word_r", 64'(gotR), 64'h00_1234_5678);
        checkEq("basic_out_ready_cycles", 64'(orCnt), 64'd40);
        checkEq("basic_in_ready_cycles", 64'(irCnt), DBUF ? 64'd40 : 64'd0);
        checkEq("basic_no_early_done", 64'(doneCnt + errCnt), 64'd0);
        checkEq("basic_tx_done", 64'(outVec()), 64'b00_0100);
        tick();
        checkEq("basic_after_done", 64'(outVec()), 64'd0);
        checkEq("basic_idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Frame arriving while bit 20 is on the line.
        loadPair(40'h12_3456_789A, 40'hFE_DCBA_9876);
        pulseFrame();
        shiftOut(19, -1, '0, '0, gotL, gotR, orCnt, irCnt, errCnt, doneCnt);
        checkEq("ferr_word_l", 64'(gotL), 64'h12_3456_789A);
        checkEq("ferr_word_r", 64'(gotR), 64'hFE_DCBA_9876);
        checkEq("ferr_pulses", 64'(errCnt), 64'd1);
        checkEq("ferr_out_ready_cycles", 64'(orCnt), 64'd40);
        checkEq("ferr_tx_done", 64'(outVec()), 64'b00_0100);
        tick();

        // Second pair offered mid-word, frame coincident with tx_done.
        loadPair(40'hAA_AAAA_AAAA, 40'h55_5555_5555);
        pulseFrame();
        shiftOut(39, 5, 40'h8F_F0F0_0F0F, 40'hBC_C3C3_3C3C, gotL, gotR, orCnt, irCnt, errCnt, doneCnt);
        checkEq("dbuf_first_l", 64'(gotL), 64'hAA_AAAA_AAAA);
        checkEq("dbuf_first_r", 64'(gotR), 64'h55_5555_5555);
`ifdef P2S_DOUBLE_BUF_EN
        checkEq("dbuf_in_ready_cycles", 64'(irCnt), 64'd6);
        checkEq("dbuf_seam_outs", 64'(outVec()), 64'b11_1100);
        checkEq("dbuf_seam_in_ready", 64'(bus.in_ready), 64'd1);
        shiftOut(-1, -1, '0, '0, gotL, gotR, orCnt, irCnt, errCnt, doneCnt);
        checkEq("dbuf_second_l", 64'(gotL), 64'h8F_F0F0_0F0F);
        checkEq("dbuf_second_r", 64'(gotR), 64'hBC_C3C3_3C3C);
        checkEq("dbuf_second_cycles", 64'(orCnt), 64'd40);
        checkEq("dbuf_second_done", 64'(outVec()), 64'b00_0100);
        tick();
`else
        checkEq("sbuf_in_ready_cycles", 64'(irCnt), 64'd0);
        checkEq("sbuf_done_frame_err", 64'(outVec()), 64'b00_0101);
        tick();
        bus.frame = 1'b1;
        tick();
        bus.frame = 1'b0;
        checkEq("sbuf_pair_not_taken", 64'(outVec()), 64'b00_0010);
        tick();
`endif

        // Asynchronous reset while bit 10 is on the line.
        loadPair(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
        pulseFrame();
        repeat (29) tick();
        checkEq("rst_pre_bit10", 64'(outVec()), 64'b11_1000);
        #2;
        reset_n = 1'b0;
        #1;
        checkEq("rst_async_outs", 64'(outVec()), 64'd0);
        checkEq("rst_async_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        tick();
        checkEq("rst_no_tx_done", 64'(outVec()), 64'd0);
        reset_n = 1'b1;
        tick();
        checkEq("rst_release_outs", 64'(outVec()), 64'd0);

        // Same-edge transfer and frame from IDLE.
        bus.in_data_l = 40'h80_0000_0001;
        bus.in_data_r = 40'h7F_FFFF_FFFE;
        bus.in_valid  = 1'b1;
        bus.frame     = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.frame     = 1'b0;
        checkEq("bypass_first_bit", 64'(outVec()), 64'b10_1000);
        shiftOut(-1, -1, '0, '0, gotL, gotR, orCnt, irCnt, errCnt, doneCnt);
        checkEq("bypass_word_l", 64'(gotL), 64'h80_0000_0001);
        checkEq("bypass_word_r", 64'(gotR), 64'h7F_FFFF_FFFE);
        checkEq("bypass_cycles", 64'(orCnt), 64'd40);
        checkEq("bypass_tx_done", 64'(outVec()), 64'b00_0100);
        tick();
        checkEq("bypass_idle", 64'(outVec()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
